axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 36 +++
 rtl/axi_rd_arbiter_sel.sv | 28 ++
 rtl/axi_rd_arbiter.sv | 130 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Bus widths come from the YSYX_23060251_AXI_ADDR_BUS / _DATA_BUS macros.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 32
`endif
`ifndef YSYX_23060251_AXI_DATA_BUS
`define YSYX_23060251_AXI_DATA_BUS 32
`endif

package axi_rd_arbiter_pkg;

  localparam int unsigned AXI_ADDR_W = `YSYX_23060251_AXI_ADDR_BUS;
  localparam int unsigned AXI_DATA_W = `YSYX_23060251_AXI_DATA_BUS;
  localparam int unsigned AXI_RESP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_AR   = 3'b010,
    ST_R    = 3'b100
  } arb_state_e;

  typedef logic [0:0] mst_idx_t;

  localparam mst_idx_t M_IFU = 1'b0;
  localparam mst_idx_t M_LSU = 1'b1;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_RESP_W-1:0] resp;
  } axi_r_t;

endpackage

// File: rtl/axi_rd_arbiter_sel.sv
// Combinational request-to-grant selector for two read masters.
// ARB_RR_EN selects round-robin on contention; otherwise the LSU always wins.
module axi_arb_sel
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef ARB_RR_EN
  input  mst_idx_t   last_grant_i,
`endif
  output logic       gnt_valid_c_o,
  output mst_idx_t   gnt_idx_c_o
);

  always_comb begin
    gnt_valid_c_o = |req_i;
    gnt_idx_c_o   = M_IFU;
    if (req_i == 2'b11) begin
`ifdef ARB_RR_EN
      gnt_idx_c_o = ~last_grant_i;
`else
      gnt_idx_c_o = M_LSU;
`endif
    end else if (req_i[1]) begin
      gnt_idx_c_o = M_LSU;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU=m0, LSU=m1) AXI read-channel arbiter onto one slave, one transaction in flight.
// Define ARB_RR_EN for round-robin contention resolution; default is fixed LSU priority.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_ar_valid_i,
  input  logic [AXI_ADDR_W-1:0] m0_ar_addr_i,
  output logic                  m0_ar_ready_o,
  output logic                  m0_r_valid_o,
  output logic [AXI_DATA_W-1:0] m0_r_data_o,
  output logic [AXI_RESP_W-1:0] m0_r_resp_o,
  input  logic                  m0_r_ready_i,
  input  logic                  m1_ar_valid_i,
  input  logic [AXI_ADDR_W-1:0] m1_ar_addr_i,
  output logic                  m1_ar_ready_o,
  output logic                  m1_r_valid_o,
  output logic [AXI_DATA_W-1:0] m1_r_data_o,
  output logic [AXI_RESP_W-1:0] m1_r_resp_o,
  input  logic                  m1_r_ready_i,
  output logic                  slv_ar_valid_o,
  output logic [AXI_ADDR_W-1:0] slv_ar_addr_o,
  input  logic                  slv_ar_ready_i,
  input  logic                  slv_r_valid_i,
  input  logic [AXI_DATA_W-1:0] slv_r_data_i,
  input  logic [AXI_RESP_W-1:0] slv_r_resp_i,
  output logic                  slv_r_ready_o
);

  arb_state_e state_q, state_d;
  mst_idx_t   owner_q, owner_d;
  logic       gnt_valid;
  mst_idx_t   gnt_idx;
  logic                  own_ar_valid;
  logic [AXI_ADDR_W-1:0] own_ar_addr;
  logic                  own_r_ready;
  axi_r_t                slv_r;

`ifdef ARB_RR_EN
  mst_idx_t last_grant_q, last_grant_d;
`endif

  axi_arb_sel u_sel (
    .req_i         ({m1_ar_valid_i, m0_ar_valid_i}),
`ifdef ARB_RR_EN
    .last_grant_i  (last_grant_q),
`endif
    .gnt_valid_c_o (gnt_valid),
    .gnt_idx_c_o   (gnt_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= M_IFU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_grant_q <= M_LSU;
    else       last_grant_q <= last_grant_d;
  end
`endif

  // Owner-side views of the master channels.
  assign own_ar_valid = (owner_q == M_LSU) ? m1_ar_valid_i : m0_ar_valid_i;
  assign own_ar_addr  = (owner_q == M_LSU) ? m1_ar_addr_i  : m0_ar_addr_i;
  assign own_r_ready  = (owner_q == M_LSU) ? m1_r_ready_i  : m0_r_ready_i;
  assign slv_r        = {slv_r_data_i, slv_r_resp_i};

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
`ifdef ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    slv_ar_valid_o = 1'b0;
    slv_ar_addr_o  = '0;
    slv_r_ready_o  = 1'b0;
    m0_ar_ready_o  = 1'b0;
    m1_ar_ready_o  = 1'b0;
    m0_r_valid_o   = 1'b0;
    m1_r_valid_o   = 1'b0;
    m0_r_data_o    = '0;
    m1_r_data_o    = '0;
    m0_r_resp_o    = '0;
    m1_r_resp_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = ST_AR;
        end
      end
      // Grant is held even if the owner drops ar_valid; only the handshake moves on.
      ST_AR: begin
        slv_ar_valid_o = own_ar_valid;
        slv_ar_addr_o  = own_ar_addr;
        if (owner_q == M_LSU) m1_ar_ready_o = slv_ar_ready_i;
        else                  m0_ar_ready_o = slv_ar_ready_i;
        if (own_ar_valid && slv_ar_ready_i) state_d = ST_R;
      end
      ST_R: begin
        slv_r_ready_o = own_r_ready;
        if (owner_q == M_LSU) begin
          m1_r_valid_o = slv_r_valid_i;
          m1_r_data_o  = slv_r.data;
          m1_r_resp_o  = slv_r.resp;
        end else begin
          m0_r_valid_o = slv_r_valid_i;
          m0_r_data_o  = slv_r.data;
          m0_r_resp_o  = slv_r.resp;
        end
        if (slv_r_valid_i && own_r_ready) begin
          state_d = ST_IDLE;
`ifdef ARB_RR_EN
          last_grant_d = owner_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: predicted read beats are queued at request time
// and matched against r handshakes seen on either master.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int unsigned TMO = 50;

  typedef struct {
    logic        mst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_ar_valid_i, m1_ar_valid_i;
  logic [31:0] m0_ar_addr_i, m1_ar_addr_i;
  logic        m0_ar_ready_o, m1_ar_ready_o;
  logic        m0_r_valid_o, m1_r_valid_o;
  logic [31:0] m0_r_data_o, m1_r_data_o;
  logic [1:0]  m0_r_resp_o, m1_r_resp_o;
  logic        m0_r_ready_i, m1_r_ready_i;
  logic        slv_ar_valid_o;
  logic [31:0] slv_ar_addr_o;
  logic        slv_ar_ready_i;
  logic        slv_r_valid_i;
  logic [31:0] slv_r_data_i;
  logic [1:0]  slv_r_resp_i;
  logic        slv_r_ready_o;

  exp_t        sb_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned n_rhs = 0;
  int          cnt0 = 0;
  int          cnt1 = 0;

  axi_rd_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_ready_o(m0_ar_ready_o),
    .m0_r_valid_o(m0_r_valid_o), .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o),
    .m0_r_ready_i(m0_r_ready_i),
    .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_ready_o(m1_ar_ready_o),
    .m1_r_valid_o(m1_r_valid_o), .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o),
    .m1_r_ready_i(m1_r_ready_i),
    .slv_ar_valid_o(slv_ar_valid_o), .slv_ar_addr_o(slv_ar_addr_o), .slv_ar_ready_i(slv_ar_ready_i),
    .slv_r_valid_i(slv_r_valid_i), .slv_r_data_i(slv_r_data_i), .slv_r_resp_i(slv_r_resp_i),
    .slv_r_ready_o(slv_r_ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : {a[15:0], ~a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic push_exp(input logic mst, input logic [31:0] addr, input logic [1:0] resp);
    exp_t e;
    e.mst  = mst;
    e.addr = addr;
    e.data = slave_data(addr);
    e.resp = resp;
    sb_q.push_back(e);
  endtask

  task automatic request(input logic mst, input logic [31:0] addr, input int n);
    if (mst) begin m1_ar_valid_i = 1'b1; m1_ar_addr_i = addr; cnt1 = n; end
    else     begin m0_ar_valid_i = 1'b1; m0_ar_addr_i = addr; cnt0 = n; end
  endtask

  task automatic r_pop(input logic mst, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    n_rhs++;
    check("r_expected", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("r_master", 32'(mst), 32'(e.mst));
      check("r_data", data, e.data);
      check("r_resp", 32'(resp), 32'(e.resp));
    end
  endtask

  // R-channel monitor: every master-side handshake must match the scoreboard head.
  always @(negedge clk_i) begin
    if (m0_r_valid_o) check("r_valid_excl", 32'(m1_r_valid_o), 32'd0);
    if (m0_r_valid_o && m0_r_ready_i) r_pop(1'b0, m0_r_data_o, m0_r_resp_o);
    if (m1_r_valid_o && m1_r_ready_i) r_pop(1'b1, m1_r_data_o, m1_r_resp_o);
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0; cnt0 = 0; cnt1 = 0;
    m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
    slv_ar_ready_i = 1'b0; slv_r_valid_i = 1'b0; slv_r_data_i = '0; slv_r_resp_i = '0;
    @(negedge clk_i);
    check("rst_outputs", 32'({slv_ar_valid_o, slv_r_ready_o, m0_ar_ready_o, m1_ar_ready_o,
                              m0_r_valid_o, m1_r_valid_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Slave model for one transaction; owner taken from the scoreboard head.
  task automatic serve(input int ar_dly, input int r_dly, input int rr_hold, input logic [1:0] resp);
    int n;
    logic own;
    logic [31:0] a;
    n = 0;
    check("sb_head", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    own = sb_q[0].mst;
    @(negedge clk_i);
    while (!slv_ar_valid_o && n < int'(TMO)) begin
      @(posedge clk_i); #1; @(negedge clk_i); n++;
    end
    check("ar_wait", 32'(slv_ar_valid_o), 32'd1);
    if (!slv_ar_valid_o) return;
    for (int i = 0; i < ar_dly; i++) begin
      @(posedge clk_i); #1; @(negedge clk_i);
      check("ar_hold", 32'({slv_ar_valid_o, m0_ar_ready_o, m1_ar_ready_o}), 32'b100);
    end
    @(posedge clk_i); #1;
    slv_ar_ready_i = 1'b1;
    @(negedge clk_i);
    a = slv_ar_addr_o;
    check("ar_ready_pair", 32'({m1_ar_ready_o, m0_ar_ready_o}), own ? 32'b10 : 32'b01);
    check("ar_addr", a, sb_q[0].addr);
    @(posedge clk_i); #1;
    slv_ar_ready_i = 1'b0;
    if (own) begin
      cnt1--;
      if (cnt1 <= 0) m1_ar_valid_i = 1'b0;
      else           m1_ar_addr_i = m1_ar_addr_i + 32'd4;
    end else begin
      cnt0--;
      if (cnt0 <= 0) m0_ar_valid_i = 1'b0;
      else           m0_ar_addr_i = m0_ar_addr_i + 32'd4;
    end
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk_i);
      check("r_wait", 32'({slv_ar_valid_o, slv_r_ready_o, m0_r_valid_o, m1_r_valid_o}), 32'b0100);
      @(posedge clk_i); #1;
    end
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = slave_data(a);
    slv_r_resp_i  = resp;
    if (rr_hold > 0) begin
      if (own) m1_r_ready_i = 1'b0;
      else     m0_r_ready_i = 1'b0;
    end
    for (int i = 0; i < rr_hold; i++) begin
      @(negedge clk_i);
      check("r_hold", 32'({slv_r_ready_o, own ? m1_r_valid_o : m0_r_valid_o}), 32'b01);
      check("r_nonown", own ? 32'({m0_r_valid_o, m0_r_resp_o}) | m0_r_data_o
                            : 32'({m1_r_valid_o, m1_r_resp_o}) | m1_r_data_o, 32'd0);
      @(posedge clk_i); #1;
    end
    m0_r_ready_i = 1'b1;
    m1_r_ready_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    slv_r_valid_i = 1'b0;
    slv_r_data_i  = '0;
    slv_r_resp_i  = '0;
  endtask

  initial begin
    int unsigned hs0;
    rst_i = 1'b1;
    m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;
    m0_ar_addr_i = '0; m1_ar_addr_i = '0;
    m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
    slv_ar_ready_i = 1'b0; slv_r_valid_i = 1'b0; slv_r_data_i = '0; slv_r_resp_i = '0;
    do_reset();

    // Lone IFU request: one-cycle arbitration latency, LSU stays quiet.
    request(1'b0, 32'h8000_0000, 1);
    push_exp(1'b0, 32'h8000_0000, RESP_OKAY);
    @(negedge clk_i);
    check("gnt_lat_idle", 32'(slv_ar_valid_o), 32'd0);
    @(posedge clk_i); #1; @(negedge clk_i);
    check("gnt_lat_ar", 32'(slv_ar_valid_o), 32'd1);
    check("m1_quiet", 32'({m1_ar_ready_o, m1_r_valid_o}), 32'd0);
    @(posedge clk_i); #1;
    serve(0, 0, 0, RESP_OKAY);

    // Simultaneous requests straight after reset.
    do_reset();
    request(1'b0, 32'h8000_0000, 1);
    request(1'b1, 32'h8000_0100, 1);
`ifdef ARB_RR_EN
    push_exp(1'b0, 32'h8000_0000, RESP_OKAY);
    push_exp(1'b1, 32'h8000_0100, RESP_OKAY);
`else
    push_exp(1'b1, 32'h8000_0100, RESP_OKAY);
    push_exp(1'b0, 32'h8000_0000, RESP_OKAY);
`endif
    serve(0, 0, 0, RESP_OKAY);
    serve(0, 0, 0, RESP_OKAY);

    // Slow slave and back-pressured master: exactly one R handshake.
    hs0 = n_rhs;
    request(1'b1, 32'h8000_0200, 1);
    push_exp(1'b1, 32'h8000_0200, RESP_OKAY);
    serve(3, 4, 2, RESP_OKAY);
    check("r_hs_once", n_rhs - hs0, 32'd1);

    // SLVERR passes through unchanged and the arbiter goes idle.
    request(1'b0, 32'h8000_0300, 1);
    push_exp(1'b0, 32'h8000_0300, RESP_SLVERR);
    serve(0, 1, 0, RESP_SLVERR);
    @(negedge clk_i);
    check("idle_after_err", 32'({slv_ar_valid_o, slv_r_ready_o}), 32'd0);
    @(posedge clk_i); #1;

    // Both masters continuously valid for six transactions.
    do_reset();
    request(1'b0, 32'h8000_1000, 3);
    request(1'b1, 32'h8000_2000, 3);
`ifdef ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, 32'h8000_1000 + 32'(4 * k), RESP_OKAY);
      push_exp(1'b1, 32'h8000_2000 + 32'(4 * k), RESP_OKAY);
    end
`else
    for (int k = 0; k < 3; k++) push_exp(1'b1, 32'h8000_2000 + 32'(4 * k), RESP_OKAY);
    for (int k = 0; k < 3; k++) push_exp(1'b0, 32'h8000_1000 + 32'(4 * k), RESP_OKAY);
`endif
    repeat (6) serve(0, 0, 0, RESP_OKAY);

    // Reset while in R with slave data pending: nothing is forwarded afterwards.
    do_reset();
    request(1'b0, 32'h8000_3000, 1);
    @(posedge clk_i); #1;
    slv_ar_ready_i = 1'b1;
    @(negedge clk_i);
    check("rst_t_ar", 32'({slv_ar_valid_o, m0_ar_ready_o}), 32'b11);
    @(posedge clk_i); #1;
    slv_ar_ready_i = 1'b0; m0_ar_valid_i = 1'b0; cnt0 = 0;
    m0_r_ready_i = 1'b0;
    slv_r_valid_i = 1'b1; slv_r_data_i = 32'hDEAD_BEEF; slv_r_resp_i = RESP_OKAY;
    @(negedge clk_i);
    check("rst_t_r_fwd", 32'(m0_r_valid_o), 32'd1);
    #1 rst_i = 1'b1;
    #1 check("rst_async_idle", 32'({m0_r_valid_o, m1_r_valid_o, slv_r_ready_o, slv_ar_valid_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m0_r_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("no_r_after_rst", 32'({m0_r_valid_o, m1_r_valid_o, slv_r_ready_o}), 32'd0);
      @(posedge clk_i); #1;
    end
    slv_r_valid_i = 1'b0;

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
